// File: rtl/hack_screen_bcd.sv
// hack_screen_bcd
//   Watches the 16-bit unsigned SCREEN word of the hack CPU and, whenever it
//   changes, runs a sequential double-dabble conversion (one iteration per
//   cycle) to produce five BCD digits and a significant-digit count. A
//   one-deep pending buffer holds a change that arrives mid-conversion;
//   later changes overwrite it and set the sticky overrun flag.
//
// Ports
//   clk      in   1  rising-edge clock
//   rst      in   1  asynchronous active-high reset
//   screen   in  16  SCREEN word, unsigned
//   bcd      out 20  [19:16] ten-thousands ... [3:0] units
//   ndigits  out  3  significant digit count, 1..5
//   valid    out  1  one-cycle pulse when bcd/ndigits update
//   busy     out  1  conversion in progress (state != IDLE)
//   overrun  out  1  sticky: a pending value was overwritten
module hack_screen_bcd (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] screen,
    output logic [19:0] bcd,
    output logic [2:0]  ndigits,
    output logic        valid,
    output logic        busy,
    output logic        overrun
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state, state_nxt;
    logic [35:0] work;       // {20-bit bcd, 16-bit binary}
    logic [3:0]  iter;
    logic [15:0] ref_val;
    logic [15:0] pend_val;
    logic        pend_full;
    logic        first;
    logic        change;

    // One double-dabble iteration: correct every nibble >= 5, then shift.
    function automatic logic [35:0] dabble_step(input logic [35:0] w);
        logic [35:0] t;
        t = w;
        for (int i = 0; i < 5; i++) begin
            if (t[16+4*i +: 4] >= 4'd5)
                t[16+4*i +: 4] = t[16+4*i +: 4] + 4'd3;
        end
        return {t[34:0], 1'b0};
    endfunction

    // Index of highest non-zero digit + 1; a zero value still shows one digit.
    function automatic logic [2:0] count_digits(input logic [19:0] d);
        logic [2:0] n;
        n = 3'd1;
        for (int i = 1; i < 5; i++) begin
            if (d[4*i +: 4] != 4'd0)
                n = 3'(i + 1);
        end
        return n;
    endfunction

    // first forces an unconditional capture after reset, whatever ref holds.
    assign change = first || (screen != ref_val);
    assign busy   = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pend_full || change) state_nxt = SHIFT;
            SHIFT:   if (iter == 4'd15)       state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Control and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iter      <= 4'd0;
            pend_full <= 1'b0;
            first     <= 1'b1;
            overrun   <= 1'b0;
            valid     <= 1'b0;
            bcd       <= 20'd0;
            ndigits   <= 3'd1;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    iter <= 4'd0;
                    // Pending drains ahead of a fresh change; the fresh change
                    // is still unequal to ref and gets picked up next cycle.
                    if (pend_full)
                        pend_full <= 1'b0;
                    else if (change)
                        first <= 1'b0;
                end
                SHIFT: iter <= iter + 4'd1;
                DONE: begin
                    bcd     <= work[35:16];
                    ndigits <= count_digits(work[35:16]);
                    valid   <= 1'b1;
                end
                default: ;
            endcase
            if (state != IDLE && change) begin
                if (pend_full)
                    overrun <= 1'b1;
                pend_full <= 1'b1;
                first     <= 1'b0;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (pend_full) begin
                    work <= {20'd0, pend_val};
                end else if (change) begin
                    work    <= {20'd0, screen};
                    ref_val <= screen;
                end
            end
            SHIFT:   work <= dabble_step(work);
            default: ;
        endcase
        if (state != IDLE && change) begin
            pend_val <= screen;
            ref_val  <= screen;
        end
    end

endmodule

// File: tb/tb_hack_screen_bcd.sv
module tb_hack_screen_bcd;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] screen = 16'd0;
    logic [19:0] bcd;
    logic [2:0]  ndigits;
    logic        valid;
    logic        busy;
    logic        overrun;

    hack_screen_bcd dut (
        .clk     (clk),
        .rst     (rst),
        .screen  (screen),
        .bcd     (bcd),
        .ndigits (ndigits),
        .valid   (valid),
        .busy    (busy),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [19:0] bcd;
        logic [2:0]  nd;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   passed = 0;
    int   total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act === want)
            passed++;
        else
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
    endtask

    // Drive a value at a negedge; its capture edge is the next posedge and
    // valid is visible 17 edges after that.
    task automatic drive_expect(input logic [15:0] v, input logic [19:0] b, input logic [2:0] n);
        exp_t e;
        screen = v;
        e.bcd = b;
        e.nd  = n;
        e.cyc = cyc + 18;
        q.push_back(e);
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while ((q.size() != 0 || busy) && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) check("drain_timeout", 32'd1, 32'd0);
        @(negedge clk);
    endtask

    // Monitor: pop and compare on every valid pulse.
    always @(negedge clk) begin
        if (valid) begin
            if (q.size() == 0) begin
                check("unexpected_valid", {12'd0, bcd}, 32'hFFFFF);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("bcd", {12'd0, bcd}, {12'd0, e.bcd});
                check("ndigits", {29'd0, ndigits}, {29'd0, e.nd});
                check("valid_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_bcd", {12'd0, bcd}, 32'd0);
        check("rst_ndigits", {29'd0, ndigits}, 32'd1);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);

        // First-sample rule with screen held at 0
        rst = 1'b0;
        begin
            exp_t e;
            e.bcd = 20'h00000; e.nd = 3'd1; e.cyc = cyc + 18;
            q.push_back(e);
        end
        wait_drain();
        repeat (100) @(negedge clk);

        drive_expect(16'd13, 20'h00013, 3'd2);    wait_drain();
        drive_expect(16'd21, 20'h00021, 3'd2);    wait_drain();
        drive_expect(16'd65535, 20'h65535, 3'd5); wait_drain();
        drive_expect(16'd10000, 20'h10000, 3'd5); wait_drain();
        drive_expect(16'd9, 20'h00009, 3'd1);     wait_drain();

        // Pending buffer: 200 overwritten by 300, 300 output 18 cycles after 100
        begin
            exp_t e;
            drive_expect(16'd100, 20'h00100, 3'd3);
            e.bcd = 20'h00300; e.nd = 3'd3; e.cyc = cyc + 36;
            q.push_back(e);
            @(negedge clk);
            check("overrun_before", {31'd0, overrun}, 32'd0);
            @(negedge clk);
            screen = 16'd200;
            @(negedge clk);
            screen = 16'd300;
            @(negedge clk);
            check("overrun_set", {31'd0, overrun}, 32'd1);
        end
        wait_drain();
        check("overrun_sticky", {31'd0, overrun}, 32'd1);

        // Glitch between edges is invisible
        screen = 16'd555;
        #2 screen = 16'd300;
        repeat (30) @(negedge clk);

        // Reset mid-conversion aborts it
        screen = 16'd1234;
        repeat (6) @(negedge clk);
        check("abort_busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("abort_bcd", {12'd0, bcd}, 32'd0);
        check("abort_ndigits", {29'd0, ndigits}, 32'd1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_overrun", {31'd0, overrun}, 32'd0);
        check("abort_valid", {31'd0, valid}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        begin
            exp_t e;
            e.bcd = 20'h01234; e.nd = 3'd4; e.cyc = cyc + 18;
            q.push_back(e);
        end
        wait_drain();

        // Fibonacci-style SCREEN sequence, spaced >= 18 cycles
        begin
            logic [15:0] fv [8];
            logic [19:0] fb [8];
            logic [2:0]  fn [8];
            fv = '{16'd1, 16'd2, 16'd3, 16'd5, 16'd8, 16'd89, 16'd233, 16'd28657};
            fb = '{20'h00001, 20'h00002, 20'h00003, 20'h00005, 20'h00008,
                   20'h00089, 20'h00233, 20'h28657};
            fn = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd3, 3'd5};
            for (int i = 0; i < 8; i++) begin
                drive_expect(fv[i], fb[i], fn[i]);
                repeat (20) @(negedge clk);
            end
        end
        wait_drain();
        check("final_overrun", {31'd0, overrun}, 32'd0);
        check("final_queue_empty", q.size(), 32'd0);
        repeat (30) @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
